// File: rtl/spi_regbank_pkg.sv
// rtl/spi_regbank_pkg.sv - shared types, constants and helpers for the SPI register bank
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        DATA_WR = 2'd2,
        DATA_RD = 2'd3
    } state_t;

    // Position of the read/write flag, counted down from the command word MSB
    localparam int CMD_RW_BIT = 0;

    // Mode encoding is {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_regbank_burst_if.sv
// rtl/spi_regbank_burst_if.sv - SPI pin bundle between bus master and register bank
interface spi_regbank_burst_if;
    logic spi_cs_n;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_cs_n,
        output spi_clk,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_cs_n,
        input  spi_clk,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/spi_sclk_edge.sv
// rtl/spi_sclk_edge.sv - oversampled SCLK edge detector producing sample/shift pulses
module spi_sclk_edge (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic sclk,
    input  logic cpol,
    input  logic cpha,
    output logic sample_pulse,
    output logic shift_pulse
);

    logic sclk_q;
    logic leading;
    logic trailing;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sclk_q <= 1'b0;
        end else if (ena) begin
            sclk_q <= sclk;
        end
    end

    // Leading edge leaves the idle (cpol) level, trailing edge returns to it
    assign leading  = (sclk_q == cpol) && (sclk != cpol);
    assign trailing = (sclk_q != cpol) && (sclk == cpol);

    assign sample_pulse = ena && (cpha ? trailing : leading);
    assign shift_pulse  = ena && (cpha ? leading  : trailing);

endmodule

// File: rtl/spi_regbank_burst.sv
// rtl/spi_regbank_burst.sv - SPI slave register bank with burst access and status snapshot
module spi_regbank_burst
    import spi_regbank_pkg::*;
#(
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH  = 8,
    parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic                             ena,
    input  logic [1:0]                       mode,
    spi_regbank_burst_if.slave               spi,
    output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
    output logic [NUM_CFG-1:0]               cfg_upd,
    input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
    output logic                             busy
);

    localparam int AW  = REG_WIDTH - 1;
    localparam int CIW = addr_width(NUM_CFG);
    localparam int SIW = addr_width(NUM_STATUS);
    localparam int BCW = addr_width(REG_WIDTH);
    localparam logic [AW-1:0]  CFG_END  = AW'(NUM_CFG);
    localparam logic [AW-1:0]  LAST     = AW'(NUM_CFG + NUM_STATUS - 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(REG_WIDTH - 1);

    state_t               state;
    logic [1:0]           mode_q;
    logic                 cs_q;
    logic [BCW-1:0]       bit_cnt;
    logic [AW-1:0]        addr;
    logic [REG_WIDTH-2:0] shift_in;
    logic [REG_WIDTH-1:0] tx_sr;
    logic [REG_WIDTH-1:0] cfg_q     [NUM_CFG];
    logic [REG_WIDTH-1:0] shadow    [NUM_STATUS];
    logic [REG_WIDTH-1:0] status_in [NUM_STATUS];

    logic                 sample_pulse;
    logic                 shift_pulse;
    logic [REG_WIDTH-1:0] word;
    logic [REG_WIDTH-1:0] rd_data;
    logic [AW-1:0]        next_addr;
    logic [AW-1:0]        s_off;
    logic [CIW-1:0]       cidx;
    logic [SIW-1:0]       sidx;

    spi_sclk_edge u_edge (
        .clk          (clk),
        .rstb         (rstb),
        .ena          (ena),
        .sclk         (spi.spi_clk),
        .cpol         (mode_q[1]),
        .cpha         (mode_q[0]),
        .sample_pulse (sample_pulse),
        .shift_pulse  (shift_pulse)
    );

    for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg
        assign config_regs[i*REG_WIDTH +: REG_WIDTH] = cfg_q[i];
    end

    for (genvar i = 0; i < NUM_STATUS; i++) begin : g_sts
        assign status_in[i] = status_regs[i*REG_WIDTH +: REG_WIDTH];
    end

    assign word      = {shift_in, spi.spi_mosi};
    assign s_off     = addr - CFG_END;
    assign cidx      = addr[CIW-1:0];
    assign sidx      = s_off[SIW-1:0];
    assign next_addr = (addr >= LAST) ? '0 : addr + AW'(1);
    assign spi.spi_miso = tx_sr[REG_WIDTH-1];

    always_comb begin
        rd_data = '0;
        if (addr < CFG_END) begin
            rd_data = cfg_q[cidx];
        end else if (addr <= LAST) begin
            rd_data = shadow[sidx];
        end
    end

    // CS high is checked before any SCLK pulse so an abort always wins over a word commit
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= IDLE;
            mode_q   <= MODE0;
            cs_q     <= 1'b1;
            bit_cnt  <= '0;
            addr     <= '0;
            shift_in <= '0;
            tx_sr    <= '0;
            cfg_upd  <= '0;
            busy     <= 1'b0;
            for (int i = 0; i < NUM_CFG; i++) begin
                cfg_q[i] <= CFG_RESET[i*REG_WIDTH +: REG_WIDTH];
            end
            for (int i = 0; i < NUM_STATUS; i++) begin
                shadow[i] <= '0;
            end
        end else if (ena) begin
            cs_q    <= spi.spi_cs_n;
            cfg_upd <= '0;
            if (state == IDLE) begin
                if (cs_q && !spi.spi_cs_n) begin
                    mode_q  <= mode;
                    shadow  <= status_in;
                    bit_cnt <= '0;
                    tx_sr   <= '0;
                    state   <= CMD;
                    busy    <= 1'b1;
                end
            end else if (spi.spi_cs_n) begin
                state   <= IDLE;
                busy    <= 1'b0;
                bit_cnt <= '0;
                tx_sr   <= '0;
            end else begin
                if (sample_pulse) begin
                    shift_in <= word[REG_WIDTH-2:0];
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (state == CMD) begin
                            addr  <= word[AW-1:0];
                            state <= word[REG_WIDTH-1-CMD_RW_BIT] ? DATA_WR : DATA_RD;
                        end else if (state == DATA_WR) begin
                            if (addr < CFG_END) begin
                                cfg_q[cidx]   <= word;
                                cfg_upd[cidx] <= 1'b1;
                            end
                            addr <= next_addr;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end
                // Bit count of zero marks the first shift edge of a read word
                if (shift_pulse && state == DATA_RD) begin
                    if (bit_cnt == '0) begin
                        tx_sr <= rd_data;
                        addr  <= next_addr;
                    end else begin
                        tx_sr <= {tx_sr[REG_WIDTH-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_regbank_burst.sv
// tb/tb_spi_regbank_burst.sv - directed self-checking bench for spi_regbank_burst
module tb_spi_regbank_burst;
    import spi_regbank_pkg::*;

    localparam int HALF = 4;
    localparam logic [63:0] CFG_INIT = 64'h8877665544332211;

    logic        clk;
    logic        rstb;
    logic        ena;
    logic [1:0]  mode;
    logic [63:0] config_regs;
    logic [7:0]  cfg_upd;
    logic [63:0] status_regs;
    logic        busy;

    int          tests;
    int          fails;
    int          upd_total;
    logic [7:0]  upd_last;
    logic        cpol;
    logic        cpha;

    spi_regbank_burst_if spi_if ();

    spi_regbank_burst #(
        .NUM_CFG    (8),
        .NUM_STATUS (8),
        .REG_WIDTH  (8),
        .CFG_RESET  (CFG_INIT)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .mode        (mode),
        .spi         (spi_if),
        .config_regs (config_regs),
        .cfg_upd     (cfg_upd),
        .status_regs (status_regs),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_upd != 8'h00) begin
            upd_total = upd_total + 1;
            upd_last  = cfg_upd;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_start(input logic [1:0] m);
        cpol = m[1];
        cpha = m[0];
        spi_if.spi_clk  = m[1];
        spi_if.spi_cs_n = 1'b1;
        mode = m;
        wait_clk(HALF);
        spi_if.spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic spi_stop();
        wait_clk(HALF);
        spi_if.spi_cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        if (!cpha) begin
            spi_if.spi_mosi = b;
            wait_clk(HALF);
            r = spi_if.spi_miso;
            spi_if.spi_clk = ~cpol;
            wait_clk(HALF);
            spi_if.spi_clk = cpol;
        end else begin
            spi_if.spi_clk  = ~cpol;
            spi_if.spi_mosi = b;
            wait_clk(HALF);
            r = spi_if.spi_miso;
            spi_if.spi_clk = cpol;
            wait_clk(HALF);
        end
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    initial begin
        logic [7:0] rx;
        logic       b;
        int         base;

        tests = 0;
        fails = 0;
        upd_total = 0;
        upd_last  = 8'h00;
        cpol = 1'b0;
        cpha = 1'b0;
        rstb = 1'b0;
        ena  = 1'b1;
        mode = MODE0;
        status_regs = 64'h5AA500FF55AA10CA;
        spi_if.spi_cs_n = 1'b1;
        spi_if.spi_clk  = 1'b0;
        spi_if.spi_mosi = 1'b0;
        wait_clk(3);
        check("reset_config", config_regs, CFG_INIT);
        check("reset_busy", busy, 1'b0);
        check("reset_miso", spi_if.spi_miso, 1'b0);
        check("reset_upd", cfg_upd, 8'h00);
        rstb = 1'b1;
        wait_clk(2);

        // Mode 0 write 0x3C to reg 2; mode input changes mid-transaction must not matter
        base = upd_total;
        spi_start(MODE0);
        mode = MODE3;
        check("m0_busy_high", busy, 1'b1);
        xfer_byte(8'h82, rx);
        check("m0_cmd_miso", rx, 8'h00);
        xfer_byte(8'h3C, rx);
        spi_stop();
        check("m0_reg2", config_regs[23:16], 8'h3C);
        check("m0_upd_count", upd_total - base, 1);
        check("m0_upd_value", upd_last, 8'h04);
        check("m0_busy_low", busy, 1'b0);

        // Mode 3 burst read of status 0..2
        spi_start(MODE3);
        xfer_byte(8'h08, rx);
        check("m3_cmd_miso", rx, 8'h00);
        xfer_byte(8'h00, rx);
        check("m3_rd0", rx, 8'hCA);
        xfer_byte(8'h00, rx);
        check("m3_rd1", rx, 8'h10);
        xfer_byte(8'h00, rx);
        check("m3_rd2", rx, 8'hAA);
        spi_stop();

        // Mode 1 burst write at 7: second word lands on a status address and is dropped
        base = upd_total;
        spi_start(MODE1);
        xfer_byte(8'h87, rx);
        xfer_byte(8'h11, rx);
        xfer_byte(8'h22, rx);
        spi_stop();
        check("m1_reg7", config_regs[63:56], 8'h11);
        check("m1_regs_low", config_regs[55:0], 56'h77665544_3C2211);
        check("m1_upd_count", upd_total - base, 1);
        check("m1_upd_value", upd_last, 8'h80);

        // Mode 2 read at the last status address wraps to config reg 0
        spi_start(MODE2);
        xfer_byte(8'h0F, rx);
        xfer_byte(8'h00, rx);
        check("m2_rd_last", rx, 8'h5A);
        xfer_byte(8'h00, rx);
        check("m2_rd_wrap", rx, 8'h11);
        spi_stop();

        // Partial write word is discarded on CS rise, next transaction is normal
        base = upd_total;
        spi_start(MODE0);
        xfer_byte(8'h81, rx);
        for (int i = 0; i < 5; i++) begin
            xfer_bit(1'b1, b);
        end
        spi_stop();
        check("part_reg1", config_regs[15:8], 8'h22);
        check("part_upd_count", upd_total - base, 0);
        check("part_busy", busy, 1'b0);
        spi_start(MODE0);
        xfer_byte(8'h81, rx);
        xfer_byte(8'h5E, rx);
        spi_stop();
        check("after_reg1", config_regs[15:8], 8'h5E);
        check("after_upd_count", upd_total - base, 1);
        check("after_upd_value", upd_last, 8'h02);

        // Status change after CS fall is invisible until the next transaction
        spi_start(MODE0);
        status_regs[7:0] = 8'h3F;
        xfer_byte(8'h08, rx);
        xfer_byte(8'h00, rx);
        check("snap_old", rx, 8'hCA);
        spi_stop();
        spi_start(MODE0);
        xfer_byte(8'h08, rx);
        xfer_byte(8'h00, rx);
        check("snap_new", rx, 8'h3F);
        spi_stop();

        // Asynchronous reset in the middle of a read word
        spi_start(MODE0);
        xfer_byte(8'h09, rx);
        for (int i = 0; i < 3; i++) begin
            xfer_bit(1'b0, b);
        end
        check("pre_rst_busy", busy, 1'b1);
        rstb = 1'b0;
        #2;
        check("rst_config", config_regs, CFG_INIT);
        check("rst_busy", busy, 1'b0);
        check("rst_miso", spi_if.spi_miso, 1'b0);
        check("rst_upd", cfg_upd, 8'h00);
        wait_clk(2);
        spi_if.spi_cs_n = 1'b1;
        wait_clk(2);
        rstb = 1'b1;
        wait_clk(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
